mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage, LW/SW) of the pipelined MIPS CPU.
- Grants one access at a time and holds the memory command for a fixed number of wait states.
- Returns read data with a one-cycle ack pulse and produces per-port stall signals that the control logic uses to freeze the pipeline.
- Data port has fixed priority, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (fetch/data), memory-side and stall signals for the unified memory arbiter.
// slave = arbiter side, master = CPU pipeline plus memory model side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, stall_if, stall_mem
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access,
// data-priority with a starvation guard, fixed LAT wait states and one-cycle acks.
module mem_port_arbiter #(
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int LAT      = 2,
  parameter  int MAX_D    = 4,
  localparam int STREAK_W = $clog2(MAX_D + 1)
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state,
  output logic [STREAK_W-1:0] dbg_d_streak
);
  // Handshake: a requester raises req with stable fields and holds them until its
  // one-cycle ack; stall = req & ~ack. Fields are latched at grant, later changes ignored.
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ACK} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STREAK_W-1:0] d_streak_q, d_streak_d;
  logic                m_en_q, m_en_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_streak_d = d_streak_q;
    m_en_d     = m_en_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        // Data wins unless fetch has already waited through MAX_D data grants.
        if (bus.d_req && !(bus.i_req && d_streak_q == STREAK_W'(MAX_D))) begin
          state_d    = BUSY_D;
          cnt_d      = CNT_W'(LAT - 1);
          m_en_d     = 1'b1;
          m_we_d     = bus.d_we;
          m_addr_d   = bus.d_addr;
          m_wdata_d  = bus.d_wdata;
          d_streak_d = bus.i_req ? d_streak_q + STREAK_W'(1) : '0;
        end else if (bus.i_req) begin
          state_d    = BUSY_I;
          cnt_d      = CNT_W'(LAT - 1);
          m_en_d     = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = bus.i_addr;
          d_streak_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          m_en_d  = 1'b0;
          m_we_d  = 1'b0;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.m_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (!m_we_q) d_rdata_d = bus.m_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      d_streak_q <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_streak_q <= d_streak_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.m_en      = m_en_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = bus.i_req & ~i_ack_q;
  assign bus.stall_mem = bus.d_req & ~d_ack_q;
  assign dbg_state     = state_q;
  assign dbg_d_streak  = d_streak_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a cycle-timed transaction model predicts every
// output each cycle; a small directed sequence exercises a LAT=1 instance.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int MAX_D = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  logic [1:0] dbg_state, dbg_state1;
  logic [2:0] dbg_streak, dbg_streak1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .MAX_D(MAX_D)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state), .dbg_d_streak(dbg_streak));

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(1), .MAX_D(MAX_D)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg_state1), .dbg_d_streak(dbg_streak1));

  // bookkeeping
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit rst_next = 1'b1;
  int i_rate = 0;
  int d_rate = 0;

  // requester and model state
  bit i_act, d_act;
  bit g_act, g_d, g_we;
  int g_cyc;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  int arb_at = 0;
  int streak = 0;
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_q [$];

  bit starv_mode = 1'b0;
  int d_run = 0;
  int i_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = '0;
    a[9:2] = 8'($urandom_range(255));
    return a;
  endfunction

  // driver: one clock cycle of stimulus, model prediction and comparison
  task automatic step();
    bit busy, ack_now, grant;
    logic [DW-1:0] sb;
    @(negedge clk);
    rst = rst_next;
    if (!i_act && $urandom_range(99) < i_rate) begin
      i_act = 1'b1;
      bus.i_addr = rand_addr();
    end
    if (!d_act && $urandom_range(99) < d_rate) begin
      d_act = 1'b1;
      bus.d_we = 1'($urandom_range(1));
      bus.d_addr = rand_addr();
      bus.d_wdata = $urandom;
    end
    bus.i_req = i_act;
    bus.d_req = d_act;
    bus.m_rdata = (g_act && !g_we && cyc == g_cyc + LAT) ? mem[g_addr[9:2]] : DW'($urandom);
    #1;
    busy = g_act && cyc > g_cyc && cyc <= g_cyc + LAT;
    ack_now = g_act && cyc == g_cyc + LAT + 1;
    if (ack_now) begin
      if (!g_d) exp_i_rdata = mem[g_addr[9:2]];
      else if (!g_we) exp_d_rdata = mem[g_addr[9:2]];
    end
    if (chk_en) begin
      check_eq("m_en", bus.m_en, busy);
      check_eq("m_we", bus.m_we, busy && g_we);
      if (busy) check_eq("m_addr", bus.m_addr, g_addr);
      if (busy && g_we) check_eq("m_wdata", bus.m_wdata, g_wdata);
      check_eq("i_ack", bus.i_ack, ack_now && !g_d);
      check_eq("d_ack", bus.d_ack, ack_now && g_d);
      check_eq("i_rdata", bus.i_rdata, exp_i_rdata);
      check_eq("d_rdata", bus.d_rdata, exp_d_rdata);
      check_eq("stall_if", bus.stall_if, i_act && !(ack_now && !g_d));
      check_eq("stall_mem", bus.stall_mem, d_act && !(ack_now && g_d));
      check_eq("d_streak", dbg_streak, streak);
      if (ack_now && !(g_d && g_we)) begin
        if (exp_q.size() > 0) begin
          sb = exp_q.pop_front();
          check_eq("rd_scoreboard", g_d ? bus.d_rdata : bus.i_rdata, sb);
        end else begin
          check_eq("rd_scoreboard_empty", exp_q.size(), 1);
        end
      end
    end
    if (starv_mode) begin
      if (bus.d_ack) d_run++;
      if (bus.i_ack) begin
        if (i_seen > 0) check_eq("starv_run", d_run, MAX_D);
        i_seen++;
        d_run = 0;
      end
    end
    if (ack_now) begin
      if (g_d) begin
        if (g_we) mem[g_addr[9:2]] = g_wdata;
        d_act = 1'b0;
      end else begin
        i_act = 1'b0;
      end
      g_act = 1'b0;
    end
    if (rst) begin
      g_act = 1'b0;
      streak = 0;
      arb_at = cyc + 1;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
      exp_q.delete();
    end else if (cyc == arb_at) begin
      grant = 1'b0;
      if (d_act && !(i_act && streak == MAX_D)) begin
        g_d = 1'b1; g_we = bus.d_we; g_addr = bus.d_addr; g_wdata = bus.d_wdata;
        streak = i_act ? streak + 1 : 0;
        grant = 1'b1;
      end else if (i_act) begin
        g_d = 1'b0; g_we = 1'b0; g_addr = bus.i_addr;
        streak = 0;
        grant = 1'b1;
      end
      if (grant) begin
        g_act = 1'b1;
        g_cyc = cyc;
        arb_at = cyc + LAT + 2;
        if (!g_we) exp_q.push_back(mem[g_addr[9:2]]);
      end else begin
        arb_at = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic run_idle();
    i_rate = 0;
    d_rate = 0;
    rst_next = 1'b0;
    for (int k = 0; k < 300 && (i_act || d_act || g_act); k++) step();
    check_eq("drain", {i_act, d_act, g_act}, 3'b000);
  endtask

  task automatic start_i(input logic [AW-1:0] a);
    i_act = 1'b1;
    bus.i_addr = a;
  endtask

  task automatic start_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_act = 1'b1;
    bus.d_we = we;
    bus.d_addr = a;
    bus.d_wdata = wd;
  endtask

  initial begin
    bit hit;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.m_rdata = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.m_rdata = '0;
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    mem[16] = 32'h2002_0005;

    // reset held two cycles with both requests pending
    start_i(rand_addr());
    start_d(1'b0, rand_addr(), '0);
    rst_next = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    run_idle();

    // fetch alone, then data/fetch collision
    start_i(32'h40);
    run_idle();
    start_d(1'b1, 32'h100, 32'hDEAD_BEEF);
    start_i(32'h44);
    run_idle();

    // both requesters saturated: starvation guard
    starv_mode = 1'b1;
    i_rate = 100;
    d_rate = 100;
    for (int k = 0; k < 200; k++) step();
    starv_mode = 1'b0;
    check_eq("starv_i_seen", i_seen >= 3, 1'b1);
    run_idle();

    // reset during the second wait-state cycle of a load
    start_d(1'b0, 32'h8, '0);
    hit = 1'b0;
    for (int k = 0; k < 40 && (d_act || g_act); k++) begin
      rst_next = !hit && g_act && g_d && cyc == g_cyc + 2;
      if (rst_next) hit = 1'b1;
      step();
    end
    rst_next = 1'b0;
    check_eq("mid_rst_hit", hit, 1'b1);
    run_idle();

    // random traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      i_rate = 40;
      d_rate = 40;
      rst_next = ($urandom_range(299) == 0);
      step();
    end
    run_idle();

    // LAT=1 instance: single load
    @(negedge clk);
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h8; bus1.m_rdata = 32'hFFFF_FFF0;
    #1;
    check_eq("l1_c0_m_en", bus1.m_en, 1'b0);
    check_eq("l1_c0_stall", bus1.stall_mem, 1'b1);
    @(negedge clk); #1;
    check_eq("l1_c1_m_en", bus1.m_en, 1'b1);
    check_eq("l1_c1_m_addr", bus1.m_addr, 32'h8);
    check_eq("l1_c1_d_ack", bus1.d_ack, 1'b0);
    @(negedge clk); #1;
    check_eq("l1_c2_m_en", bus1.m_en, 1'b0);
    check_eq("l1_c2_d_ack", bus1.d_ack, 1'b1);
    check_eq("l1_c2_d_rdata", bus1.d_rdata, 32'hFFFF_FFF0);
    check_eq("l1_c2_stall", bus1.stall_mem, 1'b0);
    @(negedge clk);
    bus1.d_req = 1'b0;
    #1;
    check_eq("l1_c3_d_ack", bus1.d_ack, 1'b0);
    check_eq("l1_c3_d_rdata", bus1.d_rdata, 32'hFFFF_FFF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
